// File: rtl/des_iter_if.sv
// Valid/ready bundle between the block-mode controller, the DES core and the
// output FIFO. The master side feeds blocks in and drains results.
interface des_iter_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [63:0] in_key;
    logic        in_decrypt;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;

    modport master (
        output in_valid, in_data, in_key, in_decrypt, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_key, in_decrypt, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/des_iter_core.sv
// Iterative DES encrypt/decrypt engine. IP on accept, ROUNDS_PER_CYCLE Feistel
// rounds per clock with an on-the-fly key schedule (forward for encrypt,
// reverse for decrypt), FP of the swapped halves on the final iteration.
module des_iter_core #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    des_iter_if.slave  bus
);

    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4 &&
        ROUNDS_PER_CYCLE != 8 && ROUNDS_PER_CYCLE != 16) begin : g_bad_rpc
        $error("des_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    localparam int NUM_ITER = 16 / ROUNDS_PER_CYCLE;
    localparam int CW       = $clog2(NUM_ITER) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NUM_ITER);

    // Bit i set means key-schedule shift amount of round i+1 is 2, else 1.
    localparam logic [15:0] SHIFT2 = 16'h7EFC;

    // Tables use DES numbering: entry = source bit, bit 1 = MSB.
    localparam int IP_T [64] = '{
        58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
        62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
        57,49,41,33,25,17, 9,1, 59,51,43,35,27,19,11,3,
        61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T [64] = '{
        40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
        38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
        36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
        34,2,42,10,50,18,58,26, 33,1,41, 9,49,17,57,25};
    localparam int E_T [48] = '{
        32, 1, 2, 3, 4, 5,  4, 5, 6, 7, 8, 9,  8, 9,10,11,12,13, 12,13,14,15,16,17,
        16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32, 1};
    localparam int P_T [32] = '{
        16, 7,20,21,29,12,28,17, 1,15,23,26, 5,18,31,10,
         2, 8,24,14,32,27, 3, 9,19,13,30, 6,22,11, 4,25};
    localparam int PC1_T [56] = '{
        57,49,41,33,25,17, 9, 1,58,50,42,34,26,18,10, 2,59,51,43,35,27,19,11, 3,60,52,44,36,
        63,55,47,39,31,23,15, 7,62,54,46,38,30,22,14, 6,61,53,45,37,29,21,13, 5,28,20,12, 4};
    localparam int PC2_T [48] = '{
        14,17,11,24, 1, 5, 3,28,15, 6,21,10,23,19,12, 4,26, 8,16, 7,27,20,13, 2,
        41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};

    // S-boxes, 64 nibbles each, index {row[1:0], col[3:0]} with entry 0 at the MSB.
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
        return y;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
        return y;
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        logic [55:0] y;
        for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
        return y;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
        return y;
    endfunction

    // Round function f(R, K): expand, key mix, S-box substitution, P.
    function automatic logic [31:0] f_round(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] y;
        logic [5:0]  six;
        logic [5:0]  idx;
        for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
        x = x ^ k;
        for (int b = 0; b < 8; b++) begin
            six = x[47-6*b -: 6];
            idx = {six[5], six[0], six[4:1]};
            s[31-4*b -: 4] = SBOX[b][255-4*int'(idx) -: 4];
        end
        for (int i = 0; i < 32; i++) y[31-i] = s[32-P_T[i]];
        return y;
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    state_e         state_q;
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  cnt_d;
    logic [31:0]    l_q, r_q;
    logic [27:0]    c_q, d_q;
    logic           mode_q;
    logic [63:0]    out_data_q;
    logic           out_valid_q;

    logic [31:0]    l_d, r_d, tmp_r;
    logic [27:0]    c_d, d_d;
    logic [47:0]    k_cur;
    logic [3:0]     ri, di;
    logic           accept;

    assign bus.in_ready  = rst_n && (state_q == S_IDLE || (state_q == S_DONE && bus.out_ready));
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign accept        = bus.in_valid && bus.in_ready;
    assign cnt_d         = cnt_q + 1'b1;

    // Chain ROUNDS_PER_CYCLE rounds, rotating C/D before each key is derived.
    always_comb begin
        // NOTE: every variable gets a value before any branch so no latch is inferred.
        l_d   = l_q;
        r_d   = r_q;
        c_d   = c_q;
        d_d   = d_q;
        tmp_r = '0;
        k_cur = '0;
        ri    = '0;
        di    = '0;
        for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
            ri = 4'(int'(cnt_q) * ROUNDS_PER_CYCLE + j);
            di = 4'(16 - int'(ri));
            if (!mode_q) begin
                if (SHIFT2[ri]) begin
                    c_d = {c_d[25:0], c_d[27:26]};
                    d_d = {d_d[25:0], d_d[27:26]};
                end else begin
                    c_d = {c_d[26:0], c_d[27]};
                    d_d = {d_d[26:0], d_d[27]};
                end
            end else if (ri != 4'd0) begin
                if (SHIFT2[di]) begin
                    c_d = {c_d[1:0], c_d[27:2]};
                    d_d = {d_d[1:0], d_d[27:2]};
                end else begin
                    c_d = {c_d[0], c_d[27:1]};
                    d_d = {d_d[0], d_d[27:1]};
                end
            end
            k_cur = perm_pc2({c_d, d_d});
            tmp_r = r_d;
            r_d   = l_d ^ f_round(r_d, k_cur);
            l_d   = tmp_r;
        end
    end

    // Control FSM, round state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            l_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            mode_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            unique case (state_q)
                S_IDLE: begin
                    if (accept) state_q <= S_BUSY;
                end
                S_BUSY: begin
                    l_q   <= l_d;
                    r_q   <= r_d;
                    c_q   <= c_d;
                    d_q   <= d_d;
                    cnt_q <= cnt_d;
                    if (cnt_d == LAST_CNT) begin
                        out_data_q  <= perm_fp({r_d, l_d});
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= accept ? S_BUSY : S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            // Loading a new block; never coincides with the BUSY update above.
            if (accept) begin
                {l_q, r_q} <= perm_ip(bus.in_data);
                {c_q, d_q} <= perm_pc1(bus.in_key);
                mode_q     <= bus.in_decrypt;
                cnt_q      <= '0;
            end
        end
    end

endmodule
